// File: rtl/memload_arbiter.sv
`timescale 1ns/1ps
// memload_arbiter: shares one per-core memory write bus between NREQ loaders.
// Each loader sends a header (proc, mem, base, len) and then len data words;
// the winner keeps the bus for the whole burst, and bursts are granted
// round-robin.
// Optional build macro MEMLOAD_LOCK_EN adds a 'lock' input. While lock is
// high, no new header is granted. A burst that has already been granted
// still runs to completion.
module memload_arbiter #(
    parameter int NREQ      = 2,
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 16,
    parameter int LENWIDTH  = 16,
    parameter int NPROCSEL  = 3,
    parameter int MAXMEM    = 2
) (
    input  logic                          clk,
    input  logic                          resetn,
`ifdef MEMLOAD_LOCK_EN
    input  logic                          lock,
`endif
    input  logic [NREQ-1:0]               hdr_valid,
    output logic [NREQ-1:0]               hdr_ready,
    input  logic [NREQ*NPROCSEL-1:0]      hdr_proc,
    input  logic [NREQ*3-1:0]             hdr_mem,
    input  logic [NREQ*ADDRWIDTH-1:0]     hdr_base,
    input  logic [NREQ*LENWIDTH-1:0]      hdr_len,
    input  logic [NREQ-1:0]               dat_valid,
    output logic [NREQ-1:0]               dat_ready,
    input  logic [NREQ*DATAWIDTH-1:0]     dat_data,
    output logic [DATAWIDTH-1:0]          mem_write_data,
    output logic [ADDRWIDTH-1:0]          mem_write_addr,
    output logic [NPROCSEL-1:0]           proc_write_sel,
    output logic [2:0]                    mem_write_sel,
    output logic                          mem_write_en,
    output logic                          busy,
    output logic [$clog2(NREQ)-1:0]       grant_id,
    output logic                          burst_done,
    output logic                          err_sel,
    output logic                          err_wrap,
    input  logic                          err_clr
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, HDR, BURST, DONE} state_t;

    state_t                 state_reg;
    logic [IDW-1:0]         ptr_reg;
    logic [IDW-1:0]         grant_reg;
    logic [NPROCSEL-1:0]    proc_reg;
    logic [2:0]             mem_reg;
    logic [ADDRWIDTH-1:0]   cur_reg;
    logic [LENWIDTH-1:0]    cnt_reg;
    logic                   bad_sel_reg;
    logic [DATAWIDTH-1:0]   wdata_reg;
    logic [ADDRWIDTH-1:0]   waddr_reg;
    logic [NPROCSEL-1:0]    wproc_reg;
    logic [2:0]             wmem_reg;
    logic                   wen_reg;
    logic                   busy_reg;
    logic                   done_reg;
    logic                   err_sel_reg;
    logic                   err_wrap_reg;

    logic                   lock_w;
    logic                   win_valid;
    logic [IDW-1:0]         win_id;
    logic                   grant_en;
    logic                   accept;

`ifdef MEMLOAD_LOCK_EN
    assign lock_w = lock;
`else
    assign lock_w = 1'b0;
`endif

    // Split the flat per-requester buses into arrays so the current winner
    // or grantee can simply index them.
    logic [NPROCSEL-1:0]  f_proc [NREQ];
    logic [2:0]           f_mem  [NREQ];
    logic [ADDRWIDTH-1:0] f_base [NREQ];
    logic [LENWIDTH-1:0]  f_len  [NREQ];
    logic [DATAWIDTH-1:0] f_data [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        assign f_proc[gi]    = hdr_proc[gi*NPROCSEL +: NPROCSEL];
        assign f_mem[gi]     = hdr_mem[gi*3 +: 3];
        assign f_base[gi]    = hdr_base[gi*ADDRWIDTH +: ADDRWIDTH];
        assign f_len[gi]     = hdr_len[gi*LENWIDTH +: LENWIDTH];
        assign f_data[gi]    = dat_data[gi*DATAWIDTH +: DATAWIDTH];
        assign hdr_ready[gi] = grant_en && (win_id == IDW'(gi));
        assign dat_ready[gi] = (state_reg == BURST) && (grant_reg == IDW'(gi));
    end

    // Round-robin search. It starts at the requester after the last grant.
    // The loop runs backwards so that the closest valid requester is the one
    // whose assignment survives.
    always_comb begin
        logic [IDW-1:0] idx;
        idx       = '0;
        win_valid = 1'b0;
        win_id    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IDW'((int'(ptr_reg) + k) % NREQ);
            if (hdr_valid[idx]) begin
                win_valid = 1'b1;
                win_id    = idx;
            end
        end
    end

    // hdr_ready is gated by resetn. This keeps it low while the design is
    // held in reset, even when a loader is already presenting a header.
    assign grant_en = resetn && !lock_w && (state_reg == IDLE) && win_valid;
    assign accept   = (state_reg == BURST) && dat_valid[grant_reg];

    // Burst sequencer. It also drives the registered write bus and the
    // sticky error flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            grant_reg    <= '0;
            proc_reg     <= '0;
            mem_reg      <= '0;
            cur_reg      <= '0;
            cnt_reg      <= '0;
            bad_sel_reg  <= 1'b0;
            wdata_reg    <= '0;
            waddr_reg    <= '0;
            wproc_reg    <= '0;
            wmem_reg     <= '0;
            wen_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_sel_reg  <= 1'b0;
            err_wrap_reg <= 1'b0;
        end else begin
            wen_reg  <= 1'b0;
            done_reg <= 1'b0;
            // The clear is written first, so a set later in this block wins.
            if (err_clr) begin
                err_sel_reg  <= 1'b0;
                err_wrap_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (grant_en) begin
                        proc_reg  <= f_proc[win_id];
                        mem_reg   <= f_mem[win_id];
                        cur_reg   <= f_base[win_id];
                        cnt_reg   <= f_len[win_id];
                        grant_reg <= win_id;
                        ptr_reg   <= IDW'((int'(win_id) + 1) % NREQ);
                        busy_reg  <= 1'b1;
                        state_reg <= HDR;
                    end
                end
                HDR: begin
                    if (mem_reg > 3'(MAXMEM)) begin
                        bad_sel_reg <= 1'b1;
                        err_sel_reg <= 1'b1;
                    end
                    if (cnt_reg == '0) begin
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        state_reg <= BURST;
                    end
                end
                BURST: begin
                    if (accept) begin
                        // With an illegal memory select, words are consumed
                        // but the write bus is left untouched.
                        if (!bad_sel_reg) begin
                            wen_reg   <= 1'b1;
                            wdata_reg <= f_data[grant_reg];
                            waddr_reg <= cur_reg;
                            wproc_reg <= proc_reg;
                            wmem_reg  <= mem_reg;
                        end
                        cur_reg <= cur_reg + 1'b1;
                        cnt_reg <= cnt_reg - 1'b1;
                        if ((&cur_reg) && (cnt_reg != LENWIDTH'(1)))
                            err_wrap_reg <= 1'b1;
                        if (cnt_reg == LENWIDTH'(1)) begin
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy_reg    <= 1'b0;
                    bad_sel_reg <= 1'b0;
                    state_reg   <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign mem_write_data = wdata_reg;
    assign mem_write_addr = waddr_reg;
    assign proc_write_sel = wproc_reg;
    assign mem_write_sel  = wmem_reg;
    assign mem_write_en   = wen_reg;
    assign busy           = busy_reg;
    assign grant_id       = grant_reg;
    assign burst_done     = done_reg;
    assign err_sel        = err_sel_reg;
    assign err_wrap       = err_wrap_reg;

endmodule

// File: tb/tb_memload_arbiter.sv
`timescale 1ns/1ps
// Testbench for memload_arbiter.
// Loader agents are driven from per-requester job queues. The expected
// strobes, grant order and error flags are rebuilt from the burst rules
// (base + i modulo 2^16, legal select <= 2, strict alternation under
// contention).
module tb_memload_arbiter;
    localparam int NREQ = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic [1:0]    hdr_valid = '0;
    logic [1:0]    hdr_ready;
    logic [5:0]    hdr_proc = '0;
    logic [5:0]    hdr_mem = '0;
    logic [31:0]   hdr_base = '0;
    logic [31:0]   hdr_len = '0;
    logic [1:0]    dat_valid = '0;
    logic [1:0]    dat_ready;
    logic [63:0]   dat_data = '0;
    logic [31:0]   mem_write_data;
    logic [15:0]   mem_write_addr;
    logic [2:0]    proc_write_sel;
    logic [2:0]    mem_write_sel;
    logic          mem_write_en;
    logic          busy;
    logic [0:0]    grant_id;
    logic          burst_done;
    logic          err_sel;
    logic          err_wrap;
    logic          err_clr = 1'b0;
`ifdef MEMLOAD_LOCK_EN
    logic          lock = 1'b0;
`endif

    always #5 clk = ~clk;

    memload_arbiter dut (
        .clk(clk), .resetn(resetn),
`ifdef MEMLOAD_LOCK_EN
        .lock(lock),
`endif
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_proc(hdr_proc),
        .hdr_mem(hdr_mem), .hdr_base(hdr_base), .hdr_len(hdr_len),
        .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_data(dat_data),
        .mem_write_data(mem_write_data), .mem_write_addr(mem_write_addr),
        .proc_write_sel(proc_write_sel), .mem_write_sel(mem_write_sel),
        .mem_write_en(mem_write_en), .busy(busy), .grant_id(grant_id),
        .burst_done(burst_done), .err_sel(err_sel), .err_wrap(err_wrap),
        .err_clr(err_clr)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
        logic [2:0]  proc;
        logic [2:0]  sel;
    } strb_t;

    typedef struct {
        logic [2:0]  proc;
        logic [2:0]  mem;
        logic [15:0] base;
        int          len;
    } job_t;

    job_t  jq [NREQ][$];
    strb_t got_q[$];
    strb_t exp_q[$];
    int    grant_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    done_cnt, exp_bursts, hs_cnt;
    bit    timed_out;
    bit    exp_wrap, exp_sel;

    task automatic clear_inputs();
        hdr_valid = '0; dat_valid = '0; err_clr = 1'b0;
        hdr_proc = '0; hdr_mem = '0; hdr_base = '0; hdr_len = '0; dat_data = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        clear_inputs();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        exp_wrap = 1'b0;
        exp_sel = 1'b0;
    endtask

    task automatic add_job(input int r, input int proc, input int mem, input int base, input int len);
        job_t j;
        j.proc = 3'(proc); j.mem = 3'(mem); j.base = 16'(base); j.len = len;
        jq[r].push_back(j);
    endtask

    // Plays every queued job as a loader would, and records what the bus did
    // together with what the burst rules say it should have done.
    task automatic run_jobs(input int gap_pct, input int budget);
        job_t cur_j[NREQ];
        int   phase[NREQ];
        int   widx[NREQ];
        int   cyc = 0;
        int   drain = 0;
        bit   all_idle;
        strb_t s;
        got_q.delete(); exp_q.delete(); grant_q.delete();
        done_cnt = 0; exp_bursts = 0; hs_cnt = 0; timed_out = 1'b0;
        for (int r = 0; r < NREQ; r++) begin phase[r] = 0; widx[r] = 0; end
        forever begin
            @(negedge clk);
            if (mem_write_en) got_q.push_back({mem_write_addr, mem_write_data, proc_write_sel, mem_write_sel});
            if (burst_done) done_cnt++;
            all_idle = 1'b1;
            for (int r = 0; r < NREQ; r++) begin
                if (phase[r] == 0 && jq[r].size() > 0) begin
                    cur_j[r] = jq[r].pop_front(); phase[r] = 1; widx[r] = 0;
                end
                if (phase[r] != 0) all_idle = 1'b0;
            end
            if (all_idle && done_cnt == exp_bursts) drain++; else drain = 0;
            if (drain > 3) break;
            if (cyc++ >= budget) begin timed_out = 1'b1; break; end
            for (int r = 0; r < NREQ; r++) begin
                hdr_valid[r] = (phase[r] == 1);
                if (phase[r] == 1) begin
                    hdr_proc[r*3 +: 3]   = cur_j[r].proc;
                    hdr_mem[r*3 +: 3]    = cur_j[r].mem;
                    hdr_base[r*16 +: 16] = cur_j[r].base;
                    hdr_len[r*16 +: 16]  = 16'(cur_j[r].len);
                end
                dat_valid[r] = (phase[r] == 2) && ($urandom_range(99) >= gap_pct);
                dat_data[r*32 +: 32] = $urandom;
            end
            #1;
            n_vec++;
            if ((hdr_ready & ~hdr_valid) != '0 || !$onehot0(hdr_ready)) begin
                n_err++;
                $display("FAIL hdr_ready_onehot: hdr_ready=%b with hdr_valid=%b, required one-hot subset", hdr_ready, hdr_valid);
            end
            for (int r = 0; r < NREQ; r++) begin
                if (dat_ready[r] && phase[r] != 2) begin
                    n_err++;
                    $display("FAIL dat_ready_owner: dat_ready[%0d]=1 while requester holds no grant, required 0", r);
                end
                if (hdr_valid[r] && hdr_ready[r]) begin
                    grant_q.push_back(r);
                    exp_bursts++;
                    if (cur_j[r].mem > 3'd2) exp_sel = 1'b1;
                    if (cur_j[r].len > 0 && int'(cur_j[r].base) + cur_j[r].len - 1 > 65535) exp_wrap = 1'b1;
                    phase[r] = (cur_j[r].len == 0) ? 0 : 2;
                end else if (dat_valid[r] && dat_ready[r]) begin
                    s.addr = cur_j[r].base + 16'(widx[r]);
                    s.data = dat_data[r*32 +: 32];
                    s.proc = cur_j[r].proc;
                    s.sel  = cur_j[r].mem;
                    if (cur_j[r].mem <= 3'd2) exp_q.push_back(s);
                    hs_cnt++;
                    widx[r]++;
                    if (widx[r] == cur_j[r].len) phase[r] = 0;
                end
            end
        end
        hdr_valid = '0;
        dat_valid = '0;
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        #2 resetn = 1'b0;
        hdr_valid = 2'b11; dat_valid = 2'b11; hdr_len = 32'h0003_0003;
        #1;
        n_vec++;
        if ({hdr_ready, dat_ready, mem_write_data, mem_write_addr, proc_write_sel, mem_write_sel, mem_write_en,
             busy, grant_id, burst_done, err_sel, err_wrap} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: hdr_ready=%b dat_ready=%b en=%b busy=%b addr=%h, required all 0",
                     hdr_ready, dat_ready, mem_write_en, busy, mem_write_addr);
        end
        repeat (3) @(negedge clk);
        clear_inputs();
        resetn = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({mem_write_en, busy, burst_done, grant_id, hdr_ready, dat_ready} !== '0) begin
            n_err++;
            $display("FAIL reset_release_idle: en=%b busy=%b done=%b grant=%0d, required 0", mem_write_en, busy, burst_done, grant_id);
        end
    endtask

    task automatic test_single_burst();
        apply_reset();
        add_job(0, 1, 0, 16'h0010, 4);
        run_jobs(0, 200);
        n_vec++;
        if (timed_out || got_q.size() != 4 || exp_q.size() != 4) begin
            n_err++;
            $display("FAIL single_count: timeout=%0d strobes=%0d, required 4", timed_out, got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i] || got_q[i].addr !== 16'h0010 + 16'(i)) begin
                n_err++;
                $display("FAIL single_strobe[%0d]: got addr=%h data=%h proc=%0d sel=%0d, required addr=%h data=%h proc=%0d sel=%0d",
                         i, got_q[i].addr, got_q[i].data, got_q[i].proc, got_q[i].sel,
                         exp_q[i].addr, exp_q[i].data, exp_q[i].proc, exp_q[i].sel);
            end
        end
        n_vec++;
        if (done_cnt !== 1 || busy !== 1'b0 || grant_id !== 1'b0) begin
            n_err++;
            $display("FAIL single_done: burst_done count=%0d busy=%b grant_id=%0d, required 1/0/0", done_cnt, busy, grant_id);
        end
    endtask

    task automatic test_contention();
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < NREQ; r++)
                add_job(r, $urandom_range(7), $urandom_range(2), $urandom_range(16'hFF00), $urandom_range(5, 1));
        end
        run_jobs(20, 2000);
        n_vec++;
        if (timed_out || grant_q.size() != 8) begin
            n_err++;
            $display("FAIL contention_grants: timeout=%0d grants=%0d, required 8", timed_out, grant_q.size());
        end
        for (int i = 0; i < grant_q.size(); i++) begin
            n_vec++;
            if (grant_q[i] != i % 2) begin
                n_err++;
                $display("FAIL contention_order[%0d]: granted %0d, required %0d", i, grant_q[i], i % 2);
            end
        end
        n_vec++;
        if (got_q.size() != exp_q.size() || done_cnt != 8 || grant_id !== 1'b1) begin
            n_err++;
            $display("FAIL contention_count: strobes=%0d done=%0d grant_id=%0d, required %0d/8/1", got_q.size(), done_cnt, grant_id, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL contention_strobe[%0d]: got addr=%h data=%h, required addr=%h data=%h",
                         i, got_q[i].addr, got_q[i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    task automatic test_zero_len();
        apply_reset();
        add_job(1, 4, 1, 16'h1234, 0);
        run_jobs(0, 100);
        n_vec++;
        if (timed_out || grant_q.size() != 1 || done_cnt != 1 || got_q.size() != 0) begin
            n_err++;
            $display("FAIL zero_len: timeout=%0d grants=%0d done=%0d strobes=%0d, required 0/1/1/0",
                     timed_out, grant_q.size(), done_cnt, got_q.size());
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        add_job(0, 2, 0, 16'hFFFE, 4);
        run_jobs(30, 300);
        n_vec++;
        if (timed_out || got_q.size() != 4 || err_wrap !== exp_wrap || exp_wrap !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_flag: timeout=%0d strobes=%0d err_wrap=%b, required 4 strobes and err_wrap=1",
                     timed_out, got_q.size(), err_wrap);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL wrap_strobe[%0d]: got addr=%h data=%h, required addr=%h data=%h",
                         i, got_q[i].addr, got_q[i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    task automatic test_illegal_sel();
        apply_reset();
        add_job(0, 3, 5, 16'h0200, 3);
        run_jobs(0, 200);
        n_vec++;
        if (timed_out || hs_cnt != 3 || got_q.size() != 0 || err_sel !== exp_sel || exp_sel !== 1'b1) begin
            n_err++;
            $display("FAIL illegal_sel: timeout=%0d handshakes=%0d strobes=%0d err_sel=%b, required 3/0/1",
                     timed_out, hs_cnt, got_q.size(), err_sel);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_vec++;
        if (err_sel !== 1'b0 || err_wrap !== 1'b0) begin
            n_err++;
            $display("FAIL err_clr: err_sel=%b err_wrap=%b, required 0/0", err_sel, err_wrap);
        end
    endtask

    task automatic test_reset_mid();
        int hs = 0;
        int cyc = 0;
        bit granted = 1'b0;
        apply_reset();
        hdr_valid = 2'b01; hdr_proc[2:0] = 3'd2; hdr_mem[2:0] = 3'd1;
        hdr_base[15:0] = 16'($urandom); hdr_len[15:0] = 16'd8;
        while (hs < 2 && cyc < 50) begin
            dat_valid[0] = 1'b1;
            dat_data[31:0] = $urandom;
            #1;
            if (hdr_ready[0]) granted = 1'b1;
            if (dat_ready[0]) hs++;
            @(negedge clk);
            if (granted) hdr_valid[0] = 1'b0;
            cyc++;
        end
        n_vec++;
        if (hs != 2) begin
            n_err++;
            $display("FAIL reset_mid_progress: handshakes=%0d, required 2", hs);
        end
        #2 resetn = 1'b0;
        #1;
        n_vec++;
        if ({hdr_ready, dat_ready, mem_write_data, mem_write_addr, proc_write_sel, mem_write_sel, mem_write_en,
             busy, grant_id, burst_done, err_sel, err_wrap} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: en=%b busy=%b dat_ready=%b addr=%h, required all 0",
                     mem_write_en, busy, dat_ready, mem_write_addr);
        end
        @(negedge clk);
        clear_inputs();
        resetn = 1'b1;
        exp_wrap = 1'b0;
        exp_sel = 1'b0;
        add_job(1, 6, 2, 16'h0400, 3);
        run_jobs(0, 200);
        n_vec++;
        if (timed_out || got_q.size() != 3 || done_cnt != 1 || grant_q.size() != 1 || grant_q[0] != 1) begin
            n_err++;
            $display("FAIL reset_mid_recover: timeout=%0d strobes=%0d done=%0d, required 3 strobes and 1 done", timed_out, got_q.size(), done_cnt);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL reset_mid_strobe[%0d]: got addr=%h data=%h, required addr=%h data=%h",
                         i, got_q[i].addr, got_q[i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    task automatic test_gaps();
        int total = 0;
        int l;
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            l = $urandom_range(6);
            total += l;
            add_job($urandom_range(1), $urandom_range(7), $urandom_range(2), $urandom, l);
        end
        run_jobs(50, 3000);
        n_vec++;
        if (timed_out || hs_cnt != total || done_cnt != 6 || got_q.size() != exp_q.size() || err_wrap !== exp_wrap) begin
            n_err++;
            $display("FAIL gaps_count: timeout=%0d handshakes=%0d done=%0d strobes=%0d err_wrap=%b, required %0d/6/%0d/%b",
                     timed_out, hs_cnt, done_cnt, got_q.size(), err_wrap, total, exp_q.size(), exp_wrap);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL gaps_strobe[%0d]: got addr=%h data=%h sel=%0d, required addr=%h data=%h sel=%0d",
                         i, got_q[i].addr, got_q[i].data, got_q[i].sel, exp_q[i].addr, exp_q[i].data, exp_q[i].sel);
            end
        end
    endtask

`ifdef MEMLOAD_LOCK_EN
    task automatic test_lock();
        apply_reset();
        lock = 1'b1;
        hdr_valid = 2'b01; hdr_len[15:0] = 16'd2;
        repeat (4) begin
            @(negedge clk);
            #1;
            n_vec++;
            if (hdr_ready !== 2'b00 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL lock_hold: hdr_ready=%b busy=%b, required 00/0", hdr_ready, busy);
            end
        end
        lock = 1'b0;
        #1;
        n_vec++;
        if (hdr_ready !== 2'b01) begin
            n_err++;
            $display("FAIL lock_release: hdr_ready=%b, required 01", hdr_ready);
        end
        hdr_valid = 2'b00;
        apply_reset();
        add_job(0, 1, 1, 16'h0800, 5);
        fork
            run_jobs(0, 200);
            begin
                for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
                lock = 1'b1;
            end
        join
        lock = 1'b0;
        n_vec++;
        if (timed_out || got_q.size() != 5 || done_cnt != 1) begin
            n_err++;
            $display("FAIL lock_midburst: timeout=%0d strobes=%0d done=%0d, required 5/1", timed_out, got_q.size(), done_cnt);
        end
    endtask
`endif

    initial begin
        exp_wrap = 1'b0;
        exp_sel = 1'b0;
        test_reset();
        test_single_burst();
        test_contention();
        test_zero_len();
        test_wrap();
        test_illegal_sel();
        test_reset_mid();
        test_gaps();
`ifdef MEMLOAD_LOCK_EN
        test_lock();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
